// File: rtl/i2s_tdm_clock_gen_if.sv
// Control and clock/strobe bundle between the I2S/TDM clock generator and the
// serializers it paces.
interface i2s_tdm_clock_gen_if #(
  parameter int DIV_W = 4
);
  logic             enable;
  logic [DIV_W-1:0] div_sel;
  logic [1:0]       word_sel;
  logic             fs_mode;
  logic             BCLK;
  logic             LRCLK;
  logic             bclk_rise;
  logic             bclk_fall;
  logic             frame_start;
  logic [2:0]       slot;
  logic [4:0]       bit_idx;
  logic             active;

  modport master (
    input  enable, div_sel, word_sel, fs_mode,
    output BCLK, LRCLK, bclk_rise, bclk_fall, frame_start, slot, bit_idx, active
  );

  modport slave (
    output enable, div_sel, word_sel, fs_mode,
    input  BCLK, LRCLK, bclk_rise, bclk_fall, frame_start, slot, bit_idx, active
  );
endinterface

// File: rtl/i2s_tdm_clock_gen.sv
// I2S/TDM master clock generator: BCLK, LRCLK and per-edge strobes are all
// registers in the SAICLK domain, paced by a half-period down-counter.
module i2s_tdm_clock_gen #(
  parameter int SLOTS = 2,
  parameter int DIV_W = 4
) (
  input logic                  SAICLK,
  input logic                  reset,
  i2s_tdm_clock_gen_if.master  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);
  localparam logic [2:0] HALF_SLOT = 3'(SLOTS / 2);

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_word;
  logic             r_fs;
  logic [DIV_W-1:0] r_half_cnt;
  logic             r_bclk;
  logic             r_lrclk;
  logic             r_rise;
  logic             r_fall;
  logic             r_fstart;
  logic [2:0]       r_slot;
  logic [4:0]       r_bit;
  logic             r_active;

  // Last bit index of a slot; word_sel 3 is treated as 32-bit.
  function automatic logic [4:0] last_bit(input logic [1:0] ws);
    case (ws)
      2'd0:    last_bit = 5'd15;
      2'd1:    last_bit = 5'd23;
      default: last_bit = 5'd31;
    endcase
  endfunction

  logic       w_bit_wrap;
  logic       w_frame_end;
  logic [2:0] w_slot_next;
  logic [4:0] w_bit_next;
  logic       w_lr_next;

  assign w_bit_wrap  = (r_bit == last_bit(r_word));
  assign w_frame_end = w_bit_wrap && (r_slot == LAST_SLOT);
  assign w_slot_next = w_bit_wrap ? r_slot + 3'd1 : r_slot;
  assign w_bit_next  = w_bit_wrap ? 5'd0 : r_bit + 5'd1;
  // Mid-frame positions are never p=0, so the DSP pulse is always low here.
  assign w_lr_next   = r_fs ? 1'b0 : (w_slot_next >= HALF_SLOT);

  always_ff @(posedge SAICLK) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_word     <= 2'd0;
      r_fs       <= 1'b0;
      r_half_cnt <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_fstart   <= 1'b0;
      r_slot     <= 3'd0;
      r_bit      <= 5'd0;
      r_active   <= 1'b0;
    end else begin
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_fstart <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.enable) begin
            r_div      <= bus.div_sel;
            r_word     <= bus.word_sel;
            r_fs       <= bus.fs_mode;
            r_half_cnt <= bus.div_sel;
            r_bclk     <= 1'b0;
            r_lrclk    <= bus.fs_mode;
            r_fstart   <= 1'b1;
            r_slot     <= 3'd0;
            r_bit      <= 5'd0;
            r_active   <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (r_half_cnt != '0) begin
            r_half_cnt <= r_half_cnt - 1'b1;
          end else if (!r_bclk) begin
            r_bclk     <= 1'b1;
            r_rise     <= 1'b1;
            r_half_cnt <= r_div;
          end else begin
            r_bclk <= 1'b0;
            r_fall <= 1'b0 | 1'b1;
            if (w_frame_end) begin
              // Frame boundary: new config governs the reload made on this edge.
              r_div      <= bus.div_sel;
              r_word     <= bus.word_sel;
              r_fs       <= bus.fs_mode;
              r_half_cnt <= bus.div_sel;
              r_slot     <= 3'd0;
              r_bit      <= 5'd0;
              if (bus.enable) begin
                r_fstart <= 1'b1;
                r_lrclk  <= bus.fs_mode;
              end else begin
                r_lrclk  <= 1'b0;
                r_active <= 1'b0;
                r_state  <= IDLE;
              end
            end else begin
              r_half_cnt <= r_div;
              r_slot     <= w_slot_next;
              r_bit      <= w_bit_next;
              r_lrclk    <= w_lr_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.BCLK        = r_bclk;
  assign bus.LRCLK       = r_lrclk;
  assign bus.bclk_rise   = r_rise;
  assign bus.bclk_fall   = r_fall;
  assign bus.frame_start = r_fstart;
  assign bus.slot        = r_slot;
  assign bus.bit_idx     = r_bit;
  assign bus.active      = r_active;

endmodule

// File: tb/tb_i2s_tdm_clock_gen.sv
// Scoreboard bench: stimulus queues expected strobe events (cycle, levels,
// position); per-DUT monitors pop and compare whenever a strobe appears.
module tb_i2s_tdm_clock_gen;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   cut;

  typedef struct {
    int   cyc;
    logic rise;
    logic fall;
    logic fs;
    logic bclk;
    logic lr;
    logic act;
    int   slot;
    int   bidx;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  i2s_tdm_clock_gen_if #(.DIV_W(4)) b0 ();
  i2s_tdm_clock_gen_if #(.DIV_W(4)) b1 ();

  i2s_tdm_clock_gen #(.SLOTS(2), .DIV_W(4)) u0 (.SAICLK(clk), .reset(rst_n), .bus(b0.master));
  i2s_tdm_clock_gen #(.SLOTS(8), .DIV_W(4)) u1 (.SAICLK(clk), .reset(rst_n), .bus(b1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int qsize(input int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic void push(input int d, input ev_t e);
    if (e.cyc >= cut) return;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Expected strobe events of one frame starting at cycle s; returns next frame start.
  function automatic int push_frame(input int d, input int s, input int div, input int w,
                                    input int fsm, input int slots, input bit first,
                                    input bit last);
    int  n;
    int  h;
    ev_t e;
    n = slots * w;
    h = div + 1;
    e.cyc = s; e.rise = 0; e.fall = !first; e.fs = 1; e.bclk = 0;
    e.lr = (fsm != 0); e.act = 1; e.slot = 0; e.bidx = 0;
    push(d, e);
    for (int p = 0; p < n; p++) begin
      e.cyc = s + (2 * p + 1) * h; e.rise = 1; e.fall = 0; e.fs = 0; e.bclk = 1;
      e.lr = (fsm != 0) ? (p == 0) : (p >= n / 2); e.act = 1;
      e.slot = p / w; e.bidx = p % w;
      push(d, e);
      if (p < n - 1) begin
        e.cyc = s + (2 * p + 2) * h; e.rise = 0; e.fall = 1; e.bclk = 0;
        e.lr = (fsm != 0) ? 1'b0 : ((p + 1) >= n / 2);
        e.slot = (p + 1) / w; e.bidx = (p + 1) % w;
        push(d, e);
      end
    end
    if (last) begin
      e.cyc = s + 2 * n * h; e.rise = 0; e.fall = 1; e.fs = 0; e.bclk = 0;
      e.lr = 0; e.act = 0; e.slot = 0; e.bidx = 0;
      push(d, e);
    end
    return s + 2 * n * h;
  endfunction

  task automatic mon(input int d, input logic r, input logic f, input logic fsb,
                     input logic bc, input logic lr, input logic act,
                     input logic [2:0] sl, input logic [4:0] bi);
    ev_t e;
    while (qsize(d) > 0) begin
      if (d == 0) e = q0[0];
      else        e = q1[0];
      if (e.cyc >= cyc) break;
      vectors++;
      miscompares++;
      $display("FAIL missed_strobe dut%0d: expected event at cycle %0d, still pending at cycle %0d",
               d, e.cyc, cyc);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    if (r || f || fsb) begin
      vectors++;
      if (qsize(d) == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe dut%0d cyc=%0d got rise=%0b fall=%0b fs=%0b, expected none",
                 d, cyc, r, f, fsb);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.cyc != cyc || e.rise !== r || e.fall !== f || e.fs !== fsb || e.bclk !== bc ||
            e.lr !== lr || e.act !== act || e.slot != int'(sl) || e.bidx != int'(bi)) begin
          miscompares++;
          $display("FAIL strobe dut%0d got cyc=%0d r=%0b f=%0b fs=%0b bclk=%0b lr=%0b act=%0b slot=%0d bit=%0d, expected cyc=%0d r=%0b f=%0b fs=%0b bclk=%0b lr=%0b act=%0b slot=%0d bit=%0d",
                   d, cyc, r, f, fsb, bc, lr, act, sl, bi,
                   e.cyc, e.rise, e.fall, e.fs, e.bclk, e.lr, e.act, e.slot, e.bidx);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.bclk_rise, b0.bclk_fall, b0.frame_start, b0.BCLK, b0.LRCLK, b0.active,
        b0.slot, b0.bit_idx);
    mon(1, b1.bclk_rise, b1.bclk_fall, b1.frame_start, b1.BCLK, b1.LRCLK, b1.active,
        b1.slot, b1.bit_idx);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int d, input int budget);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qsize(d) != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout dut%0d: %0d expected events outstanding, required 0", d, qsize(d));
      if (d == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  function automatic int outs0();
    return int'({b0.BCLK, b0.LRCLK, b0.bclk_rise, b0.bclk_fall, b0.frame_start,
                 b0.active, b0.slot, b0.bit_idx});
  endfunction

  initial begin
    int s;
    int s0;
    int rcyc;
    vectors = 0;
    miscompares = 0;
    cut = 32'h3fff_ffff;
    rst_n = 1'b0;
    b0.enable = 0; b0.div_sel = 0; b0.word_sel = 0; b0.fs_mode = 0;
    b1.enable = 0; b1.div_sel = 0; b1.word_sel = 0; b1.fs_mode = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs_dut0", outs0(), 0);
    chk("reset_outs_dut1", int'({b1.BCLK, b1.LRCLK, b1.bclk_rise, b1.bclk_fall,
                                 b1.frame_start, b1.active, b1.slot, b1.bit_idx}), 0);

    // 32-bit, div 0, I2S: two frames, enable dropped during the second.
    rst_n = 1'b1;
    b0.div_sel = 4'd0; b0.word_sel = 2'd2; b0.fs_mode = 1'b0; b0.enable = 1'b1;
    s = push_frame(0, cyc + 1, 0, 32, 0, 2, 1'b1, 1'b0);
    s = push_frame(0, s, 0, 32, 0, 2, 1'b0, 1'b1);
    wait_until(s - 70);
    b0.enable = 1'b0;
    drain(0, 300);
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clk);
      chk("idle_hold_bclk_lr_active", int'({b0.BCLK, b0.LRCLK, b0.active}), 0);
    end

    // 16-bit, div 2, I2S: single frame, re-enable from IDLE.
    b0.div_sel = 4'd2; b0.word_sel = 2'd0; b0.enable = 1'b1;
    s0 = cyc + 1;
    s = push_frame(0, s0, 2, 16, 0, 2, 1'b1, 1'b1);
    wait_until(s0 + 10);
    b0.enable = 1'b0;
    drain(0, 300);

    // Mid-frame change of div/fs/word is deferred to the boundary.
    b0.div_sel = 4'd0; b0.word_sel = 2'd0; b0.fs_mode = 1'b0; b0.enable = 1'b1;
    s0 = cyc + 1;
    s = push_frame(0, s0, 0, 16, 0, 2, 1'b1, 1'b0);
    s = push_frame(0, s, 3, 32, 1, 2, 1'b0, 1'b1);
    wait_until(s0 + 49);
    b0.div_sel = 4'd3; b0.fs_mode = 1'b1; b0.word_sel = 2'd3;
    wait_until(s0 + 100);
    b0.enable = 1'b0;
    drain(0, 700);

    // Reset asserted mid-frame, then restart with enable held high.
    b0.div_sel = 4'd1; b0.word_sel = 2'd1; b0.fs_mode = 1'b0; b0.enable = 1'b1;
    s0 = cyc + 1;
    rcyc = s0 + 37;
    cut = rcyc;
    s = push_frame(0, s0, 1, 24, 0, 2, 1'b1, 1'b0);
    wait_until(rcyc - 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midframe_reset_outs", outs0(), 0);
    chk("midframe_reset_queue", qsize(0), 0);
    cut = 32'h3fff_ffff;
    rst_n = 1'b1;
    s0 = cyc + 1;
    s = push_frame(0, s0, 1, 24, 0, 2, 1'b1, 1'b1);
    wait_until(s0 + 20);
    b0.enable = 1'b0;
    drain(0, 300);

    // SLOTS=8, 24-bit, div 1, DSP frame pulse.
    b1.div_sel = 4'd1; b1.word_sel = 2'd1; b1.fs_mode = 1'b1; b1.enable = 1'b1;
    s0 = cyc + 1;
    s = push_frame(1, s0, 1, 24, 1, 8, 1'b1, 1'b1);
    wait_until(s0 + 100);
    b1.enable = 1'b0;
    drain(1, 1000);
    repeat (4) @(negedge clk);
    chk("dut1_idle_after_frame", int'({b1.BCLK, b1.LRCLK, b1.active}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tdm_clock_gen.md
# i2s_tdm_clock_gen

Runtime-configurable I2S/TDM master clock generator producing BCLK and LRCLK/frame-sync as registered outputs of the single SAICLK domain, using internal clock-enable counters rather than derived clocks. It supports 16/24/32-bit word lengths, a parametrised slot count per frame, and I2S or DSP short-pulse framing. Configuration changes take effect only at frame boundaries, so changes are glitch-free. Per-edge strobes and slot/bit indices are provided so downstream serializers run in the SAICLK domain. It sits between the SAI clock source and the I2S/TDM data shifters.

## Interface
- SLOTS, default 2: slots per frame; legal range 2..8; must be even when I2S mode is used.
- DIV_W, default 4: width of the BCLK half-period divider select.
- SAICLK  in  1  sole clock; all logic and outputs on its rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  run request; sampled in IDLE and at frame boundaries only.
- div_sel  in  DIV_W  BCLK half-period = div_sel+1 SAICLK cycles.
- word_sel  in  2  word length: 0=16, 1=24, 2=32, 3=32.
- fs_mode  in  1  framing: 0=I2S 50% LRCLK, 1=DSP one-BCLK frame pulse.
- BCLK  out  1  bit clock.
- LRCLK  out  1  word select / frame sync.
- bclk_rise  out  1  one-cycle strobe, high in the cycle BCLK first reads 1.
- bclk_fall  out  1  one-cycle strobe, high in the cycle BCLK first reads 0 after a high phase.
- frame_start  out  1  one-cycle strobe at bit position 0 of every frame.
- slot  out  3  current slot index, 0..SLOTS-1.
- bit_idx  out  5  bit index within slot; 0 = MSB.
- active  out  1  high while in RUN.

## Operation
- States: IDLE, RUN.
- Reset (reset=0 on a clock edge) forces IDLE. On the next edge the outputs read: BCLK=0, LRCLK=0, all strobes=0, slot=0, bit_idx=0, active=0. This applies mid-frame as well.
- IDLE with enable=1:
  - Latch div_sel, word_sel and fs_mode into shadow registers.
  - Enter RUN with half_cnt=div, frame position p=0, BCLK=0.
  - Assert frame_start.
  - Set LRCLK to its p=0 value.
- RUN, each cycle:
  - If half_cnt≠0, decrement it.
  - Otherwise toggle BCLK and reload half_cnt from the shadow div.
- Frame length N = SLOTS*W, where W is the latched word length. Maximum N is 256.
- Frame position p, with slot = p/W and bit_idx = p mod W, advances only on the 1→0 BCLK toggle. LRCLK updates on that same edge.
- LRCLK encoding:
  - I2S: LRCLK=0 for p<N/2, 1 otherwise.
  - DSP: LRCLK=1 only for p=0.
- Frame boundary, the falling toggle where p wraps N-1→0:
  - Re-latch the shadow config. The new div applies to the reload performed on that edge.
  - If enable=1: p=0 and frame_start pulses.
  - If enable=0: go to IDLE with BCLK=0, LRCLK=0, no frame_start pulse, active=0.
- Changes to div_sel, word_sel or fs_mode mid-frame have no effect until the boundary.
- Deasserting enable mid-frame always completes the current frame.
- Shadow word_sel=3 behaves exactly as 2.

## Timing
- IDLE→RUN takes 1 cycle after enable is seen. frame_start is high in the first RUN cycle.
- First BCLK rise occurs div+1 cycles after RUN entry.
- BCLK period is 2(div+1) SAICLK cycles with exactly 50% duty.
- Frame length is 2(div+1)·N SAICLK cycles.
- Strobes are registered and coincide with the BCLK/LRCLK register update. No combinational paths from inputs to outputs.
- With div=0, BCLK = SAICLK/2; bclk_rise and bclk_fall alternate every cycle.
- Simultaneous reset=0 and a boundary: reset wins.
- Simultaneous enable=0 and the IDLE→RUN decision: stay in IDLE.

## Test plan
- SLOTS=2, word_sel=2, div=0, I2S, enable=1 after reset:
  - BCLK period is 2 cycles.
  - LRCLK is low 64 and high 64 SAICLK cycles.
  - frame_start every 128 cycles.
  - bit_idx runs 0..31 twice per frame.
- word_sel=0, div=2, I2S:
  - BCLK high 3 / low 3 cycles.
  - Frame is 192 cycles.
  - LRCLK toggles on bclk_fall at p=16.
- SLOTS=8, word_sel=1, div=1, DSP:
  - LRCLK high exactly 4 cycles every 768 cycles, coincident with frame_start.
  - slot steps 0..7, each lasting 24 BCLKs.
- Change div_sel 0→3 and fs_mode 0→1 at cycle 50 of a frame:
  - Remainder of the frame is unchanged.
  - From the boundary, BCLK period is 8 and LRCLK is a 1-BCLK pulse.
- Drop enable mid-frame:
  - Frame completes.
  - BCLK=LRCLK=active=0 held afterwards.
  - Re-asserting enable gives frame_start 1 cycle later.
- Assert reset=0 at an arbitrary mid-frame cycle:
  - Next edge shows all outputs at reset values.
  - Release with enable=1 restarts at p=0.
